// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared state, error-code and width definitions for the instruction loader.
package prog_loader_pkg;
    typedef enum logic [3:0] {
        IDLE, LEN_LO, LEN_HI, INS_LO, INS_HI, START, RUN, FINISH, ERROR
    } loader_state_t;
    typedef enum logic [1:0] {ERR_NONE, ERR_HIBYTE, ERR_LEN, ERR_TIMEOUT} err_code_t;
    localparam int INSTR_W = 9;
endpackage

// File: rtl/prog_loader.sv
// prog_loader: streams a length-prefixed byte program into instruction memory,
// starts the processor and reports run length, completion or error to the host.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int unsigned DEPTH          = 1024,
    parameter int unsigned START_CYCLES   = 2,
    parameter int unsigned MAX_RUN_CYCLES = 1000000
) (
    input  logic               CLK,
    input  logic               reset,
    input  logic               go,
    input  logic               in_valid,
    input  logic [7:0]         in_data,
    output logic               in_ready,
    output logic               imem_we,
    output logic [15:0]        imem_addr,
    output logic [INSTR_W-1:0] imem_wdata,
    output logic               start,
    input  logic               done,
    output logic               busy,
    output logic               run_done,
    output logic [31:0]        run_cycles,
    output logic [1:0]         err_code
);
    loader_state_t state;
    logic [7:0]    len_lo;
    logic [15:0]   len;
    logic [7:0]    lo;
    logic [15:0]   addr;
    logic [31:0]   start_cnt;
    logic [31:0]   cnt;
    logic          accept;

    assign in_ready = state inside {LEN_LO, LEN_HI, INS_LO, INS_HI};
    assign busy     = !(state inside {IDLE, FINISH, ERROR});
    assign accept   = in_valid & in_ready;

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            len_lo     <= '0;
            len        <= '0;
            lo         <= '0;
            addr       <= '0;
            start_cnt  <= '0;
            cnt        <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            start      <= 1'b0;
            run_done   <= 1'b0;
            run_cycles <= '0;
            err_code   <= ERR_NONE;
        end else begin
            imem_we <= 1'b0;
            case (state)
                IDLE, FINISH, ERROR: if (go) begin
                    state      <= LEN_LO;
                    run_done   <= 1'b0;
                    err_code   <= ERR_NONE;
                    run_cycles <= '0;
                    addr       <= '0;
                end
                LEN_LO: if (accept) begin
                    len_lo <= in_data;
                    state  <= LEN_HI;
                end
                LEN_HI: if (accept) begin
                    len  <= {in_data, len_lo};
                    addr <= '0;
                    if ({in_data, len_lo} == 16'd0 || {1'b0, in_data, len_lo} > 17'(DEPTH)) begin
                        state    <= ERROR;
                        err_code <= ERR_LEN;
                    end else
                        state <= INS_LO;
                end
                INS_LO: if (accept) begin
                    lo    <= in_data;
                    state <= INS_HI;
                end
                INS_HI: if (accept) begin
                    if (in_data[7:1] != 7'd0) begin
                        state    <= ERROR;
                        err_code <= ERR_HIBYTE;
                    end else begin
                        imem_we    <= 1'b1;
                        imem_addr  <= addr;
                        imem_wdata <= {in_data[0], lo};
                        addr       <= addr + 16'd1;
                        if (addr + 16'd1 == len) begin
                            state     <= START;
                            start     <= 1'b1;
                            start_cnt <= '0;
                        end else
                            state <= INS_LO;
                    end
                end
                START: begin
                    start_cnt <= start_cnt + 32'd1;
                    if (start_cnt >= START_CYCLES - 1) begin
                        start <= 1'b0;
                        state <= RUN;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    if (done) begin
                        run_cycles <= cnt;
                        run_done   <= 1'b1;
                        state      <= FINISH;
                    end else if (MAX_RUN_CYCLES != 0 && cnt >= MAX_RUN_CYCLES) begin
                        run_cycles <= cnt;
                        err_code   <= ERR_TIMEOUT;
                        state      <= ERROR;
                    end else if (cnt != '1)
                        cnt <= cnt + 32'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed byte-stream vectors against prog_loader with hand-computed results.
module tb_prog_loader;
    import prog_loader_pkg::*;

    typedef logic [7:0] bq_t[$];

    logic        CLK = 1'b0;
    logic        reset = 1'b0;
    logic        go = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_ready;
    logic        imem_we;
    logic [15:0] imem_addr;
    logic [8:0]  imem_wdata;
    logic        start;
    logic        done = 1'b0;
    logic        busy;
    logic        run_done;
    logic [31:0] run_cycles;
    logic [1:0]  err_code;

    int          tests = 0;
    int          fails = 0;
    int          wtot = 0;
    int          stot = 0;
    logic [15:0] waddr[32];
    logic [8:0]  wdata[32];

    prog_loader #(.DEPTH(1024), .START_CYCLES(2), .MAX_RUN_CYCLES(50)) dut (
        .CLK(CLK), .reset(reset), .go(go), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .start(start), .done(done), .busy(busy),
        .run_done(run_done), .run_cycles(run_cycles), .err_code(err_code)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (imem_we) begin
            if (wtot < 32) begin
                waddr[wtot] = imem_addr;
                wdata[wtot] = imem_wdata;
            end
            wtot = wtot + 1;
        end
        if (start) stot = stot + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic pulse_go();
        go = 1'b1;
        tick();
        go = 1'b0;
    endtask

    task automatic send(input bq_t s, input bit bp);
        foreach (s[i]) begin
            int t = 0;
            in_data = s[i];
            while (bp && $urandom_range(1, 0) == 0) begin
                in_valid = 1'b0;
                tick();
            end
            in_valid = 1'b1;
            while (!in_ready && t < 50) begin
                tick();
                t++;
            end
            if (t >= 50) check("accept_timeout", 32'(t), 32'd0);
            tick();
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_start_done();
        int t = 0;
        while (!start && t < 50) begin tick(); t++; end
        while (start && t < 50) begin tick(); t++; end
        if (t >= 50) check("start_wait", 32'(t), 32'd0);
    endtask

    task automatic run_normal(input string tag, input bit bp);
        int w0 = wtot;
        int s0 = stot;
        pulse_go();
        check({tag, "_busy_load"}, 32'(busy), 32'd1);
        check({tag, "_rundone_clr"}, 32'(run_done), 32'd0);
        send('{8'h03, 8'h00, 8'h5A, 8'h01, 8'hFF, 8'h00, 8'h00, 8'h01}, bp);
        wait_start_done();
        repeat (10) tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();
        check({tag, "_nwrites"}, 32'(wtot - w0), 32'd3);
        check({tag, "_a0"}, 32'(waddr[w0]), 32'd0);
        check({tag, "_d0"}, 32'(wdata[w0]), 32'h15A);
        check({tag, "_a1"}, 32'(waddr[w0+1]), 32'd1);
        check({tag, "_d1"}, 32'(wdata[w0+1]), 32'h0FF);
        check({tag, "_a2"}, 32'(waddr[w0+2]), 32'd2);
        check({tag, "_d2"}, 32'(wdata[w0+2]), 32'h100);
        check({tag, "_start_cycles"}, 32'(stot - s0), 32'd2);
        check({tag, "_run_done"}, 32'(run_done), 32'd1);
        check({tag, "_run_cycles"}, run_cycles, 32'd10);
        check({tag, "_err"}, 32'(err_code), 32'(ERR_NONE));
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_addr_hold"}, 32'(imem_addr), 32'd2);
    endtask

    task automatic run_bad(input string tag, input bq_t s, input logic [1:0] exp_err);
        int w0 = wtot;
        int s0 = stot;
        pulse_go();
        send(s, 1'b0);
        repeat (3) tick();
        check({tag, "_err"}, 32'(err_code), 32'(exp_err));
        check({tag, "_nwrites"}, 32'(wtot - w0), 32'd0);
        check({tag, "_start"}, 32'(stot - s0), 32'd0);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        repeat (2) tick();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_we", 32'(imem_we), 32'd0);
        check("rst_start", 32'(start), 32'd0);
        check("rst_err", 32'(err_code), 32'd0);
        check("rst_cycles", run_cycles, 32'd0);
        reset = 1'b1;
        tick();
        go = 1'b0;
        in_valid = 1'b1;
        tick();
        check("idle_ignores_valid", 32'(busy), 32'd0);
        in_valid = 1'b0;

        run_normal("normal", 1'b0);
        run_bad("len_zero", '{8'h00, 8'h00}, ERR_LEN);
        run_bad("len_long", '{8'h01, 8'h04}, ERR_LEN);
        run_bad("hibyte", '{8'h01, 8'h00, 8'h12, 8'h02}, ERR_HIBYTE);
        run_normal("backpressure", 1'b1);

        begin
            int t = 0;
            pulse_go();
            send('{8'h01, 8'h00, 8'hAB, 8'h00}, 1'b0);
            wait_start_done();
            while (busy && t < 200) begin tick(); t++; end
            check("timeout_bounded", 32'(t < 200), 32'd1);
            check("timeout_err", 32'(err_code), 32'(ERR_TIMEOUT));
            check("timeout_cycles", run_cycles, 32'd50);
            check("timeout_run_done", 32'(run_done), 32'd0);
        end

        pulse_go();
        send('{8'h02, 8'h00, 8'h34}, 1'b0);
        check("pre_rst_in_ready", 32'(in_ready), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("async_in_ready", 32'(in_ready), 32'd0);
        check("async_busy", 32'(busy), 32'd0);
        check("async_addr", 32'(imem_addr), 32'd0);
        check("async_wdata", 32'(imem_wdata), 32'd0);
        check("async_start", 32'(start), 32'd0);
        check("async_err", 32'(err_code), 32'd0);
        #2 reset = 1'b1;
        tick();
        run_normal("restart", 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Host-side writer for the processor's instruction memory.
- Accepts a byte stream over a valid/ready handshake and assembles 9-bit instructions. It writes them to consecutive instruction-memory addresses starting at 0.
- After loading, it pulses the processor START, then waits for the processor DONE.
- It reports completion, the run cycle count, or an error to the host.

Parameters:
- DEPTH, 1024: instruction-memory depth in instructions; maximum accepted program length.
- INSTR_W, 9: instruction width; fixed by the ISA.
- START_CYCLES, 2: number of cycles START is held high.
- MAX_RUN_CYCLES, 1000000: run timeout in cycles; 0 disables the timeout.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- go  in  1  one-cycle request to begin a load session.
- in_valid  in  1  host byte valid.
- in_data  in  8  host byte.
- in_ready  out  1  loader accepts a byte this cycle.
- imem_we  out  1  instruction-memory write strobe.
- imem_addr  out  16  instruction-memory write address.
- imem_wdata  out  9  instruction word to write.
- start  out  1  processor START / init.
- done  in  1  processor DONE, level-sensitive.
- busy  out  1  high in every state except IDLE, FINISH and ERROR.
- run_done  out  1  sticky; program completed.
- run_cycles  out  32  cycle count of the last run.
- err_code  out  2  0 none, 1 bad high byte, 2 bad length, 3 timeout.

Behaviour:
- Reset (reset=0, asynchronous):
  - State returns to IDLE.
  - All outputs go to 0.
  - Internal counters clear.
  - Instruction memory contents are not touched.
- Byte transfer:
  - A byte is accepted only on a cycle with in_valid & in_ready.
  - in_valid while in_ready=0 is ignored, with no state change.
  - in_data is sampled only on an accepted cycle.
- Stream format:
  - First two bytes: len, little-endian (low byte first).
  - Then 2 bytes per instruction: lo = instr[7:0]; hi = {7'b0, instr[8]}.
- States: IDLE, LEN_LO, LEN_HI, INS_LO, INS_HI, START, RUN, FINISH, ERROR.
- IDLE / FINISH / ERROR:
  - in_ready=0.
  - go=1 moves to LEN_LO and clears run_done, err_code, run_cycles and the address counter.
  - go is ignored in all other states.
- LEN_LO:
  - in_ready=1.
  - On accept, latch the low length byte and move to LEN_HI.
- LEN_HI:
  - in_ready=1.
  - On accept, form len.
  - If len==0 or len>DEPTH, move to ERROR with err_code=2.
  - Otherwise move to INS_LO with addr=0.
- INS_LO:
  - in_ready=1.
  - On accept, latch lo and move to INS_HI.
- INS_HI:
  - in_ready=1.
  - On accept with in_data[7:1]!=0: move to ERROR, err_code=1, no write.
  - Otherwise, in the next cycle: imem_we=1 for exactly one cycle, imem_addr=addr, imem_wdata={in_data[0], lo}; then addr increments.
  - If addr+1==len, go to START; otherwise go to INS_LO.
  - Write latency is 1 cycle after the accept. Because the next instruction needs two more accepts, back-to-back writes never overlap.
- START:
  - start=1 for exactly START_CYCLES cycles; done is ignored.
  - Then start=0 and move to RUN with the cycle counter=0.
- RUN:
  - If done=1: run_cycles=counter, run_done=1, move to FINISH.
  - Otherwise counter+1.
  - If MAX_RUN_CYCLES!=0 and counter reaches MAX_RUN_CYCLES with done still 0: move to ERROR, err_code=3, run_cycles=counter.
  - A done that is already high on the first RUN cycle gives run_cycles=0.
- Outputs:
  - imem_addr holds its last value between writes.
  - The 32-bit counter saturates; it never wraps.
- Reset mid-operation (any state): abort immediately. A partially loaded program is left in memory, and the host must resend it.

Decomposition:
- The shared definitions package gets:
  - typedef enum loader_state_t (the 9 states);
  - typedef enum err_code_t {ERR_NONE, ERR_HIBYTE, ERR_LEN, ERR_TIMEOUT};
  - localparam INSTR_W=9.
- Single module. The FSM plus three counters (address, START cycles, run cycles) is too small to justify a sub-module.

Test Plan:
- Normal load and run:
  - Stimulus: go; bytes 03 00 5A 01 FF 00 00 01; done raised after 10 RUN cycles.
  - Response: writes addr0=0x15A, addr1=0x0FF, addr2=0x100, one imem_we cycle each; start high 2 cycles; run_done=1, run_cycles=10, err_code=0, busy=0.
- Bad length, zero: bytes 00 00 -> err_code=2, no imem_we, in_ready=0 afterwards.
- Bad length, too long: bytes 01 04 (len 1025) with DEPTH=1024 -> err_code=2.
- Bad high byte: bytes 01 00 12 02 -> err_code=1, no write, start never asserted.
- Backpressure: same stream as the normal case with in_valid randomly deasserted 50% of cycles -> identical writes and result; no byte is lost or duplicated.
- Timeout: MAX_RUN_CYCLES=50 and done held 0 -> ERROR with err_code=3 and run_cycles=50.
- Reset then restart: reset=0 asserted in INS_HI -> all outputs 0 asynchronously the same cycle; after release, go plus a full stream completes normally.
